// File: rtl/bug_eval_pkg.sv
// Shared definitions for the bug_eval result-checking slice: word widths and
// the checker state encoding.
package bug_eval_pkg;

   localparam int DATA_W = 5;
   localparam int CNT_W  = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } chk_state_t;

endpackage

// File: rtl/bug_sync_fifo.sv
// Small synchronous show-ahead FIFO; dout always presents the head entry.
module bug_sync_fifo #(
   parameter int DATA_W = 5,
   parameter int DEPTH  = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              push,
   input  logic [DATA_W-1:0] din,
   input  logic              pop,
   output logic [DATA_W-1:0] dout,
   output logic              full,
   output logic              empty
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [DATA_W-1:0] mem [DEPTH];
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic [PTR_W:0]    count;
   logic              do_push;
   logic              do_pop;

   // A pop frees a slot on the same edge, so push-while-full is legal with a pop.
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign empty   = (count == '0);
   assign full    = (count == (PTR_W + 1)'(DEPTH));
   assign dout    = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= din;
      end
   end

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/bug_result_checker.sv
// Compares the bug_eval result stream against buffered expected words and
// reports error count, first failure and a pass verdict.
module bug_result_checker #(
   parameter int DATA_W      = bug_eval_pkg::DATA_W,
   parameter int FIFO_DEPTH  = 8,
   parameter int NUM_SAMPLES = 8,
   parameter int CNT_W       = bug_eval_pkg::CNT_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              exp_valid,
   input  logic [DATA_W-1:0] exp_data,
   output logic              exp_ready,
   input  logic              res_valid,
   input  logic [DATA_W-1:0] res_data,
   output logic              busy,
   output logic              done,
   output logic              pass,
   output logic [CNT_W-1:0]  err_count,
   output logic [CNT_W-1:0]  first_err_idx,
   output logic [DATA_W-1:0] first_err_got,
   output logic [DATA_W-1:0] first_err_exp,
   output logic              underrun
);

   import bug_eval_pkg::*;

   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_SAMPLES - 1);

   chk_state_t        state;
   logic [CNT_W-1:0]  sample_idx;
   logic              fifo_full;
   logic              fifo_empty;
   logic [DATA_W-1:0] head;
   logic              push;
   logic              event_valid;
   logic              pop;
   logic              mismatch;

   assign exp_ready   = !fifo_full && (state != DONE);
   assign push        = exp_valid && exp_ready;
   assign event_valid = (state == RUN) && res_valid;
   assign pop         = event_valid && !fifo_empty;
   // An empty FIFO at compare time always counts as a failure.
   assign mismatch    = fifo_empty || (res_data != head);
   assign busy        = (state == RUN);
   assign done        = (state == DONE);

   bug_sync_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .din   (exp_data),
      .pop   (pop),
      .dout  (head),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state         <= IDLE;
         sample_idx    <= '0;
         err_count     <= '0;
         first_err_idx <= '0;
         first_err_got <= '0;
         first_err_exp <= '0;
         underrun      <= 1'b0;
         pass          <= 1'b0;
      end else if ((state != RUN) && start) begin
         state         <= RUN;
         sample_idx    <= '0;
         err_count     <= '0;
         first_err_idx <= '0;
         first_err_got <= '0;
         first_err_exp <= '0;
         underrun      <= 1'b0;
         pass          <= 1'b0;
      end else if (event_valid) begin
         sample_idx <= sample_idx + 1'b1;
         if (mismatch) begin
            if (err_count != '1) err_count <= err_count + 1'b1;
            // err_count saturates instead of wrapping, so zero means no error yet.
            if (err_count == '0) begin
               first_err_idx <= sample_idx;
               first_err_got <= res_data;
               first_err_exp <= fifo_empty ? '0 : head;
            end
         end
         if (fifo_empty) underrun <= 1'b1;
         if (sample_idx == LAST_IDX) begin
            state <= DONE;
            pass  <= !mismatch && (err_count == '0) && !underrun;
         end
      end
   end

endmodule

// File: tb/tb_bug_result_checker.sv
// Directed, table-driven bench for bug_result_checker plus hand-written corner sequences.
module tb_bug_result_checker;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic       exp_valid;
   logic [4:0] exp_data;
   logic       exp_ready;
   logic       res_valid;
   logic [4:0] res_data;
   logic       busy;
   logic       done;
   logic       pass;
   logic [7:0] err_count;
   logic [7:0] first_err_idx;
   logic [4:0] first_err_got;
   logic [4:0] first_err_exp;
   logic       underrun;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      string          name;
      logic [7:0][4:0] exp_w;
      logic [7:0][4:0] res_w;
      int             err;
      int             idx;
      int             got;
      int             expv;
      int             pass_v;
      int             under_v;
   } vec_t;

   vec_t vecs[4];

   bug_result_checker #(
      .DATA_W      (5),
      .FIFO_DEPTH  (8),
      .NUM_SAMPLES (8),
      .CNT_W       (8)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .start         (start),
      .exp_valid     (exp_valid),
      .exp_data      (exp_data),
      .exp_ready     (exp_ready),
      .res_valid     (res_valid),
      .res_data      (res_data),
      .busy          (busy),
      .done          (done),
      .pass          (pass),
      .err_count     (err_count),
      .first_err_idx (first_err_idx),
      .first_err_got (first_err_got),
      .first_err_exp (first_err_exp),
      .underrun      (underrun)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input int got, input int want);
      checks++;
      if (got !== want) begin
         failures++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, got, want);
      end
   endtask

   task automatic do_reset();
      rst = 1'b1; start = 1'b0; exp_valid = 1'b0; exp_data = '0;
      res_valid = 1'b0; res_data = '0;
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic push_word(input logic [4:0] w);
      exp_valid = 1'b1; exp_data = w;
      @(posedge clk); #1;
      exp_valid = 1'b0;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic send_result(input logic [4:0] w);
      res_valid = 1'b1; res_data = w;
      @(posedge clk); #1;
      res_valid = 1'b0;
   endtask

   task automatic wait_done(input string name);
      int n = 0;
      while (!done && n < 10) begin
         @(posedge clk); #1;
         n++;
      end
      check(name, int'(done), 1);
   endtask

   task automatic check_idle_outputs(input string tag);
      check({tag, "_exp_ready"}, int'(exp_ready), 1);
      check({tag, "_busy"}, int'(busy), 0);
      check({tag, "_done"}, int'(done), 0);
      check({tag, "_pass"}, int'(pass), 0);
      check({tag, "_err_count"}, int'(err_count), 0);
      check({tag, "_first_idx"}, int'(first_err_idx), 0);
      check({tag, "_first_got"}, int'(first_err_got), 0);
      check({tag, "_first_exp"}, int'(first_err_exp), 0);
      check({tag, "_underrun"}, int'(underrun), 0);
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      // Table: all-match, one corrupted result, fully reversed, last-sample error.
      for (int i = 0; i < 8; i++) begin
         vecs[0].exp_w[i] = 5'(i);      vecs[0].res_w[i] = 5'(i);
         vecs[1].exp_w[i] = 5'(i);      vecs[1].res_w[i] = (i == 3) ? 5'b11111 : 5'(i);
         vecs[2].exp_w[i] = 5'(i);      vecs[2].res_w[i] = 5'(7 - i);
         vecs[3].exp_w[i] = 5'(10 + i); vecs[3].res_w[i] = (i == 7) ? 5'd31 : 5'(10 + i);
      end
      vecs[0].name = "match";    vecs[0].err = 0; vecs[0].idx = 0; vecs[0].got = 0;  vecs[0].expv = 0;  vecs[0].pass_v = 1; vecs[0].under_v = 0;
      vecs[1].name = "bad3";     vecs[1].err = 1; vecs[1].idx = 3; vecs[1].got = 31; vecs[1].expv = 3;  vecs[1].pass_v = 0; vecs[1].under_v = 0;
      vecs[2].name = "reversed"; vecs[2].err = 8; vecs[2].idx = 0; vecs[2].got = 7;  vecs[2].expv = 0;  vecs[2].pass_v = 0; vecs[2].under_v = 0;
      vecs[3].name = "bad_last"; vecs[3].err = 1; vecs[3].idx = 7; vecs[3].got = 31; vecs[3].expv = 17; vecs[3].pass_v = 0; vecs[3].under_v = 0;

      do_reset();
      check_idle_outputs("reset");

      for (int v = 0; v < 4; v++) begin
         do_reset();
         for (int i = 0; i < 8; i++) push_word(vecs[v].exp_w[i]);
         pulse_start();
         check({vecs[v].name, "_busy"}, int'(busy), 1);
         for (int i = 0; i < 8; i++) send_result(vecs[v].res_w[i]);
         wait_done({vecs[v].name, "_done"});
         check({vecs[v].name, "_pass"}, int'(pass), vecs[v].pass_v);
         check({vecs[v].name, "_err_count"}, int'(err_count), vecs[v].err);
         check({vecs[v].name, "_first_idx"}, int'(first_err_idx), vecs[v].idx);
         check({vecs[v].name, "_first_got"}, int'(first_err_got), vecs[v].got);
         check({vecs[v].name, "_first_exp"}, int'(first_err_exp), vecs[v].expv);
         check({vecs[v].name, "_underrun"}, int'(underrun), vecs[v].under_v);
         check({vecs[v].name, "_busy_off"}, int'(busy), 0);
      end

      // Underrun: start with an empty FIFO, one result, then finish the run empty.
      do_reset();
      pulse_start();
      send_result(5'd4);
      check("under_err_count", int'(err_count), 1);
      check("under_flag", int'(underrun), 1);
      check("under_first_exp", int'(first_err_exp), 0);
      check("under_first_got", int'(first_err_got), 4);
      for (int i = 0; i < 7; i++) send_result(5'd4);
      wait_done("under_done");
      check("under_pass", int'(pass), 0);
      check("under_err_final", int'(err_count), 8);

      // Restart from DONE: captures clear on start, then a matching stream passes.
      pulse_start();
      check("restart_busy", int'(busy), 1);
      check("restart_err_cleared", int'(err_count), 0);
      check("restart_under_cleared", int'(underrun), 0);
      check("restart_got_cleared", int'(first_err_got), 0);
      check("restart_pass_low", int'(pass), 0);
      for (int i = 0; i < 8; i++) push_word(5'(3 * i));
      for (int i = 0; i < 8; i++) send_result(5'(3 * i));
      wait_done("restart_done");
      check("restart_pass", int'(pass), 1);
      check("restart_err", int'(err_count), 0);

      // Full FIFO: eighth push drops ready, ninth push is refused, order preserved.
      do_reset();
      for (int i = 0; i < 7; i++) push_word(5'(20 + i));
      check("fill7_ready", int'(exp_ready), 1);
      push_word(5'd27);
      check("fill8_ready", int'(exp_ready), 0);
      push_word(5'd5);
      pulse_start();
      for (int i = 0; i < 8; i++) send_result(5'(20 + i));
      wait_done("fill_done");
      check("fill_pass", int'(pass), 1);
      check("fill_err", int'(err_count), 0);
      check("fill_done_ready", int'(exp_ready), 0);

      // Reset mid-run after 4 compares: outputs clear immediately and FIFO empties.
      do_reset();
      for (int i = 0; i < 8; i++) push_word(5'(i));
      pulse_start();
      for (int i = 0; i < 3; i++) send_result(5'(i));
      send_result(5'd9);
      check("midrst_pre_err", int'(err_count), 1);
      #2 rst = 1'b1;
      #1;
      check_idle_outputs("midrst");
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
      pulse_start();
      send_result(5'd4);
      check("midrst_fifo_empty", int'(underrun), 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
